// File: rtl/pc_seq_pkg.sv
// Shared constants and next-PC select encoding for the PC sequencer.
// Used by pc_sequencer and pc_ras; the stack itself is gated by PC_SEQ_RAS_EN.
package pc_seq_pkg;

    localparam int PC_INCR      = 4;
    localparam int BRANCH_SHIFT = 2;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_RETURN
    } next_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry in place.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PC_W-1:0]          push_data,
    output logic [PC_W-1:0]          top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PC_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    assign top_idx = ptr_q - PTR_W'(1);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_MAX);
    assign top     = mem_q[top_idx];
    assign count   = cnt_q;
    assign do_pop  = pop & ~empty;

    // ptr_q is the next write slot; once full it points at the oldest entry
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && do_pop) begin
            mem_d[top_idx] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with conditional/unconditional branches and an
// optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 64,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            CLK,
    input  logic            Reset_L,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            BranchNZ,
    input  logic            ALUZero,
    input  logic            Uncondbranch,
    input  logic            Link,
    input  logic            Return,
    input  logic [PC_W-1:0] SignExtImm,
    output logic [PC_W-1:0] CurrentPC,
    output logic [PC_W-1:0] NextPC,
    output logic            Redirect,
    output logic            RasEmpty,
    output logic            RasFull,
    output logic            RasErr
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] seq_pc, branch_pc, ras_top;
    logic            taken, ras_hit;
    next_sel_e       sel;

    assign seq_pc    = pc_q + PC_W'(PC_INCR);
    assign branch_pc = pc_q + (SignExtImm << BRANCH_SHIFT);
    assign taken     = Uncondbranch | (Branch & (ALUZero ^ BranchNZ));

`ifdef PC_SEQ_RAS_EN
    logic                       ras_push, ras_pop, ras_empty, ras_full;
    logic                       ras_err_q, ras_err_d;
    logic [$clog2(RAS_DEPTH):0] unused_ras_count;

    assign ras_push = Uncondbranch & Link & ~Stall;
    assign ras_pop  = Return & ~Stall;
    assign ras_hit  = Return & ~ras_empty;

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .count     (unused_ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // A pop alongside a full push frees a slot, so it is not an overflow
    always_comb begin
        ras_err_d = ras_err_q;
        if (!Stall && ((Return && ras_empty) || (ras_push && ras_full && !Return))) begin
            ras_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ras_err_q <= 1'b0;
        end else begin
            ras_err_q <= ras_err_d;
        end
    end

    assign RasEmpty = ras_empty;
    assign RasFull  = ras_full;
    assign RasErr   = ras_err_q;
`else
    logic unused_ctrl;

    assign unused_ctrl = Link ^ Return;
    assign ras_top     = '0;
    assign ras_hit     = 1'b0;
    assign RasEmpty    = 1'b1;
    assign RasFull     = 1'b0;
    assign RasErr      = 1'b0;
`endif

    always_comb begin
        sel    = SEL_SEQ;
        NextPC = seq_pc;
        if (ras_hit) begin
            sel = SEL_RETURN;
        end else if (taken) begin
            sel = SEL_BRANCH;
        end
        case (sel)
            SEL_RETURN: NextPC = ras_top;
            SEL_BRANCH: NextPC = branch_pc;
            default:    NextPC = seq_pc;
        endcase
        pc_d = Stall ? pc_q : NextPC;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign CurrentPC = pc_q;
    assign Redirect  = (NextPC != seq_pc);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; adapts its expectations to PC_SEQ_RAS_EN.
module tb_pc_sequencer;

    localparam int          PC_W      = 64;
    localparam int          RAS_DEPTH = 4;
    localparam logic [63:0] RST       = 64'h100;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    localparam logic [63:0] RET1 = RAS ? 64'h44 : 64'h84;
    localparam logic [63:0] RET2 = RAS ? 64'h48 : 64'h88;

    typedef struct {
        logic b, bnz, z, u, l, r, st, hold, hw;
        logic [63:0] imm;
        logic [63:0] want;
    } stim_t;

    logic            CLK = 1'b0;
    logic            Reset_L, Stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link, Return;
    logic [PC_W-1:0] SignExtImm, CurrentPC, NextPC;
    logic            Redirect, RasEmpty, RasFull, RasErr;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [66:0] exp_q [$];
    logic [66:0] exp;
    logic [63:0] e_next;

    logic [63:0] m_pc;
    logic [63:0] m_stack [$];
    logic        m_err;

    pc_sequencer #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_PC  (RST)
    ) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .Stall        (Stall),
        .Branch       (Branch),
        .BranchNZ     (BranchNZ),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .Link         (Link),
        .Return       (Return),
        .SignExtImm   (SignExtImm),
        .CurrentPC    (CurrentPC),
        .NextPC       (NextPC),
        .Redirect     (Redirect),
        .RasEmpty     (RasEmpty),
        .RasFull      (RasFull),
        .RasErr       (RasErr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic stim_t mk(input logic u, l, r, b, z, bnz, input logic [63:0] imm,
                                 input logic hold, hw, input logic [63:0] want);
        stim_t s;
        s.u = u; s.l = l; s.r = r; s.b = b; s.z = z; s.bnz = bnz; s.st = 1'b0;
        s.imm = imm; s.hold = hold; s.hw = hw; s.want = want;
        return s;
    endfunction

    // Reference model of the sequencer and its stack
    function automatic logic [63:0] model_next(input stim_t s);
        if (RAS && s.r && m_stack.size() > 0) return m_stack[m_stack.size()-1];
        if (s.u || (s.b && (s.z ^ s.bnz))) return m_pc + (s.imm << 2);
        return m_pc + 64'd4;
    endfunction

    function automatic logic [2:0] model_flags();
        if (!RAS) return 3'b100;
        return {m_stack.size() == 0, m_stack.size() == RAS_DEPTH, m_err};
    endfunction

    task automatic model_commit(input stim_t s);
        logic [63:0] nxt;
        if (s.st) return;
        nxt = model_next(s);
        if (RAS) begin
            if (s.r) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_err = 1'b1;
            end
            if (s.u && s.l) begin
                m_stack.push_back(m_pc + 64'd4);
                if (m_stack.size() > RAS_DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
            end
        end
        m_pc = nxt;
    endtask

    task automatic model_reset();
        m_pc = RST;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    task automatic drive(input stim_t s);
        Branch = s.b; BranchNZ = s.bnz; ALUZero = s.z; Uncondbranch = s.u;
        Link = s.l; Return = s.r; Stall = s.st; SignExtImm = s.imm;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0));
        model_reset();
        #12;
        vectors++;
        if ({CurrentPC, RasEmpty, RasFull, RasErr} !== {RST, 3'b100}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h want %h", {CurrentPC, RasEmpty, RasFull, RasErr}, {RST, 3'b100});
        end
        Reset_L = 1'b1;
        exp_q.push_back({64'h104, 3'b100});
        exp_q.push_back({64'h108, 3'b100});
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
                miscompares++;
                $display("[TB] FAIL reset_seq[%0d]: got %h want %h", i, {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
            end
        end
        m_pc = 64'h108;
    endtask

    task automatic test_branch();
        stim_t tbl [$];
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFBE, 0, 1, 64'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd4, 1, 1, 64'd16));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 64'd4, 1, 1, 64'd4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 64'd4, 1, 1, 64'd16));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 64'd4, 1, 1, 64'd16));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 64'd4, 1, 1, 64'd4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd8, 0, 1, 64'h20));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 64'h18));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 64'd4, 0, 1, 64'h1C));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e_next = tbl[i].hw ? tbl[i].want : model_next(tbl[i]);
            vectors++;
            if (NextPC !== e_next) begin
                miscompares++;
                $display("[TB] FAIL branch_next[%0d]: got %h want %h", i, NextPC, e_next);
            end
            vectors++;
            if (Redirect !== (e_next != m_pc + 64'd4)) begin
                miscompares++;
                $display("[TB] FAIL branch_redirect[%0d]: got %b want %b", i, Redirect, e_next != m_pc + 64'd4);
            end
            if (!tbl[i].hold) begin
                model_commit(tbl[i]);
                exp_q.push_back({m_pc, model_flags()});
                tick();
                exp = exp_q.pop_front();
                vectors++;
                if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL branch_state[%0d]: got %h want %h", i, {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
                end
            end
        end
    endtask

    task automatic test_return();
        stim_t tbl [$];
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd9, 0, 1, 64'h40));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'h10, 0, 1, 64'h80));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'd0, 0, 1, RET1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'd0, 0, 1, RET2));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e_next = tbl[i].hw ? tbl[i].want : model_next(tbl[i]);
            vectors++;
            if (NextPC !== e_next) begin
                miscompares++;
                $display("[TB] FAIL return_next[%0d]: got %h want %h", i, NextPC, e_next);
            end
            model_commit(tbl[i]);
            exp_q.push_back({m_pc, model_flags()});
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
                miscompares++;
                $display("[TB] FAIL return_state[%0d]: got %h want %h", i, {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t tbl [$];
        Reset_L = 1'b0;
        #1;
        Reset_L = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'd2, 0, 0, 64'd0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'd0, 0, 0, 64'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'd4, 0, 0, 64'd0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'd4, 0, 0, 64'd0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'd0, 0, 0, 64'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e_next = model_next(tbl[i]);
            vectors++;
            if (NextPC !== e_next) begin
                miscompares++;
                $display("[TB] FAIL overflow_next[%0d]: got %h want %h", i, NextPC, e_next);
            end
            model_commit(tbl[i]);
            exp_q.push_back({m_pc, model_flags()});
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
                miscompares++;
                $display("[TB] FAIL overflow_state[%0d]: got %h want %h", i, {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        int    v;
        for (int i = 0; i < 60; i++) begin
            v = int'($urandom_range(16)) - 8;
            s = mk($urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                   $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                   {{32{v[31]}}, v}, 0, 0, 64'd0);
            s.st = ($urandom_range(5) == 0);
            drive(s);
            e_next = model_next(s);
            vectors++;
            if (NextPC !== e_next) begin
                miscompares++;
                $display("[TB] FAIL random_next[%0d]: got %h want %h", i, NextPC, e_next);
            end
            model_commit(s);
            exp_q.push_back({m_pc, model_flags()});
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
                miscompares++;
                $display("[TB] FAIL random_state[%0d]: got %h want %h", i, {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
            end
        end
    endtask

    task automatic test_stall_reset();
        stim_t s;
        s = mk(1, 1, 0, 0, 0, 0, 64'd3, 0, 0, 64'd0);
        s.st = 1'b1;
        drive(s);
        e_next = m_pc + 64'd12;
        vectors++;
        if (NextPC !== e_next) begin
            miscompares++;
            $display("[TB] FAIL stall_next: got %h want %h", NextPC, e_next);
        end
        model_commit(s);
        exp_q.push_back({m_pc, model_flags()});
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: got %h want %h", {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
        end
        Reset_L = 1'b0;
        #1;
        vectors++;
        if ({CurrentPC, RasEmpty, RasFull, RasErr} !== {RST, 3'b100}) begin
            miscompares++;
            $display("[TB] FAIL stall_async_reset: got %h want %h", {CurrentPC, RasEmpty, RasFull, RasErr}, {RST, 3'b100});
        end
        Reset_L = 1'b1;
        model_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 64'd0, 0, 0, 64'd0));
        exp_q.push_back({RST + 64'd4, 3'b100});
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if ({CurrentPC, RasEmpty, RasFull, RasErr} !== exp) begin
            miscompares++;
            $display("[TB] FAIL stall_resume: got %h want %h", {CurrentPC, RasEmpty, RasFull, RasErr}, exp);
        end
    endtask

    initial begin
        $display("[TB] pc_sequencer bench start, RAS=%0d", RAS);
        test_reset();
        test_branch();
        test_return();
        test_overflow();
        test_random();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
